// File: rtl/scan_mux_clock.sv
// scan_mux_clock: time-multiplexed display driver for the digital clock.
// Picks a window of DIGITS source digits starting at a frame-latched offset
// and scans them one at a time onto a shared BCD bus with a one-hot select.
// Digits flagged in update_mask blink at a rate locked to the scan frame.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   bcd_src      packed source digits, src[i] = bcd_src[4i+3:4i]
//   offset       source index shown on display position 0 (taken at frame wrap)
//   update_mask  bit i set: source digit i is being edited
//   blink_en     enables blinking of masked digits
//   digit_sel    one-hot select of the displayed position (all-zero in reset)
//   bcd_out      value for the selected position (BLANK when blanked/out of range)
//   frame_start  one-cycle pulse on the first cycle of each scan frame
module scan_mux_clock #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SRC_DIGITS   = 6,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter logic [3:0]  BLANK        = 4'hF,
  localparam int unsigned OFFW        = (SRC_DIGITS <= 2) ? 1 : $clog2(SRC_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*SRC_DIGITS-1:0] bcd_src,
  input  logic [OFFW-1:0]         offset,
  input  logic [SRC_DIGITS-1:0]   update_mask,
  input  logic                    blink_en,
  output logic [DIGITS-1:0]       digit_sel,
  output logic [3:0]              bcd_out,
  output logic                    frame_start
);

  localparam int unsigned PW   = $clog2(SCAN_DIV);
  localparam int unsigned IDXW = $clog2(DIGITS);
  localparam int unsigned FW   = (BLINK_FRAMES <= 1) ? 1 : $clog2(BLINK_FRAMES);
  localparam int unsigned SW   = OFFW + 4;

  localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IDXW-1:0] IDX_MAX   = IDXW'(DIGITS - 1);
  localparam logic [FW-1:0]   FCNT_MAX  = FW'(BLINK_FRAMES - 1);

  // ST_START is the single cycle out of reset: it opens frame 0 at position 0
  // without advancing the prescaler, so position 0 still gets a full dwell.
  typedef enum logic {
    ST_START,
    ST_SCAN
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              blink_q, blink_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [3:0]        bcd_q, bcd_d;
  logic              frame_start_q, frame_start_d;

  logic [SW-1:0]     src_idx;
  logic [3:0]        src_val;
  logic              src_valid;
  logic              src_masked;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    idx_d         = idx_q;
    fcnt_d        = fcnt_q;
    blink_d       = blink_q;
    off_d         = off_q;
    frame_start_d = 1'b0;

    case (state_q)
      ST_START: begin
        state_d       = ST_SCAN;
        frame_start_d = 1'b1;
      end
      default: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (idx_q == IDX_MAX) begin
            idx_d         = '0;
            off_d         = offset;
            frame_start_d = 1'b1;
            if (fcnt_q == FCNT_MAX) begin
              fcnt_d  = '0;
              blink_d = ~blink_q;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    endcase

    // Output is computed from next-state values so a new offset or blink
    // phase lands together on the first digit of the new frame.
    src_idx    = {4'b0000, off_d} + SW'(idx_d);
    src_val    = '0;
    src_valid  = 1'b0;
    src_masked = 1'b0;
    for (int unsigned i = 0; i < SRC_DIGITS; i++) begin
      if (src_idx == SW'(i)) begin
        src_valid  = 1'b1;
        src_val    = bcd_src[4*i +: 4];
        src_masked = update_mask[i];
      end
    end

    if (!src_valid) begin
      bcd_d = BLANK;
    end else if (src_masked && blink_en && !blink_d) begin
      bcd_d = BLANK;
    end else begin
      bcd_d = src_val;
    end

    digit_sel_d = DIGITS'(1) << idx_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_START;
      presc_q       <= '0;
      idx_q         <= '0;
      fcnt_q        <= '0;
      blink_q       <= 1'b1;
      off_q         <= '0;
      digit_sel_q   <= '0;
      bcd_q         <= BLANK;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      fcnt_q        <= fcnt_d;
      blink_q       <= blink_d;
      off_q         <= off_d;
      digit_sel_q   <= digit_sel_d;
      bcd_q         <= bcd_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign digit_sel   = digit_sel_q;
  assign bcd_out     = bcd_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_mux_clock.sv
// Testbench for scan_mux_clock (DIGITS=4, SRC_DIGITS=6, SCAN_DIV=3,
// BLINK_FRAMES=2). The driver applies inputs on the falling edge and pushes
// the expected output for the next rising edge; a monitor pops and compares
// just after each rising edge. Expected values come from cycle arithmetic:
// position = (t/SCAN_DIV) % DIGITS, frame = t/(DIGITS*SCAN_DIV).
module tb_scan_mux_clock;

  localparam int D     = 4;
  localparam int S     = 6;
  localparam int SD    = 3;
  localparam int BF    = 2;
  localparam int FRAME = D * SD;

  logic           clk;
  logic           reset;
  logic [4*S-1:0] bcd_src;
  logic [2:0]     offset;
  logic [S-1:0]   update_mask;
  logic           blink_en;
  logic [D-1:0]   digit_sel;
  logic [3:0]     bcd_out;
  logic           frame_start;

  scan_mux_clock #(
    .DIGITS      (D),
    .SRC_DIGITS  (S),
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF),
    .BLANK       (4'hF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_src    (bcd_src),
    .offset     (offset),
    .update_mask(update_mask),
    .blink_en   (blink_en),
    .digit_sel  (digit_sel),
    .bcd_out    (bcd_out),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] sel;
    logic [3:0] bcd;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // stimulus globals
  int         src_v[S];
  logic [2:0] g_off;
  logic [S-1:0] g_mask;
  logic       g_blink;

  // reference-model state
  int t_next  = 0;
  int cur_off = 0;

  task automatic step(input logic rst);
    exp_t e;
    int   t, pos, frame, s;
    bit   vis;
    @(negedge clk);
    reset       = rst;
    offset      = g_off;
    update_mask = g_mask;
    blink_en    = g_blink;
    for (int i = 0; i < S; i++) bcd_src[4*i +: 4] = 4'(src_v[i]);
    if (rst) begin
      e.t   = -1;
      e.sel = 4'b0000;
      e.bcd = 4'hF;
      e.fs  = 1'b0;
      t_next = 0;
    end else begin
      t      = t_next;
      t_next = t_next + 1;
      pos    = (t / SD) % D;
      frame  = t / FRAME;
      e.t    = t;
      e.fs   = (t % FRAME) == 0;
      if (e.fs) cur_off = (t == 0) ? 0 : int'(g_off);
      vis    = ((frame / BF) % 2) == 0;
      s      = cur_off + pos;
      if (s >= S)                          e.bcd = 4'hF;
      else if (g_mask[s] && g_blink && !vis) e.bcd = 4'hF;
      else                                 e.bcd = 4'(src_v[s]);
      e.sel = 4'(1 << pos);
    end
    q.push_back(e);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (digit_sel !== e.sel || bcd_out !== e.bcd || frame_start !== e.fs) begin
          n_bad++;
          $display("FAIL outputs t=%0d: got sel=%b bcd=%h fs=%b, expected sel=%b bcd=%h fs=%b",
                   e.t, digit_sel, bcd_out, frame_start, e.sel, e.bcd, e.fs);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int init_src[S] = '{9, 1, 5, 4, 3, 2};
    reset       = 1'b1;
    offset      = '0;
    update_mask = '0;
    blink_en    = 1'b0;
    bcd_src     = '0;
    for (int i = 0; i < S; i++) src_v[i] = init_src[i];
    g_off   = 3'd0;
    g_mask  = '0;
    g_blink = 1'b0;

    // reset, then offset window sequence
    step(1'b1);
    step(1'b1);
    while (t_next < 4) step(1'b0);
    g_off = 3'd2;                       // mid-frame change: takes effect next frame
    while (t_next < 3 * FRAME) step(1'b0);
    g_off = 3'd4;                       // set right before the wrap cycle
    while (t_next < 4 * FRAME) step(1'b0);
    g_off = 3'd7;
    while (t_next < 6 * FRAME) step(1'b0);

    // blink of masked position 2
    g_off  = 3'd0;
    step(1'b1);
    step(1'b1);
    g_mask = 6'b000100;
    while (t_next <= 3 * FRAME + 6) begin
      g_blink = !(t_next >= 2 * FRAME + 7 && t_next <= 2 * FRAME + 9);
      step(1'b0);
    end
    g_blink = 1'b1;
    step(1'b1);                         // reset while position 2 of frame 3 shown
    while (t_next < 3 * FRAME) step(1'b0);

    // randomized traffic, including non-BCD codes and occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < S; i++) src_v[i] = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) g_mask = 6'($urandom);
      if ($urandom_range(0, 7) == 0) g_blink = 1'($urandom);
      if ($urandom_range(0, 9) == 0) g_off = 3'($urandom);
      step($urandom_range(0, 149) == 0);
    end

    step(1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_mux_clock.md
# scan_mux_clock

Parametrised, time-multiplexed display driver for the digital clock. It selects a window of DIGITS BCD digits out of SRC_DIGITS clock digits and scans them one at a time onto a common BCD bus with a one-hot digit select. Digits flagged for editing blink at a frame-locked rate. It sits between the clock/set logic and the 7-segment decoder and anode drivers.

## Interface

Parameters:
- DIGITS, 4: display positions scanned, 2..8.
- SRC_DIGITS, 6: source BCD digits, index 0 = S1, 1 = S2, 2 = M1, 3 = M2, 4 = H1, 5 = H2; range 2..16.
- SCAN_DIV, 50000: clock cycles per digit dwell, ≥2.
- BLINK_FRAMES, 64: full scan frames per blink half-period, ≥1.
- BLANK, 4'hF: code driven for blanked or out-of-range digits.

Ports (OFFW = max(1, $clog2(SRC_DIGITS))):
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bcd_src  in  4*SRC_DIGITS  packed source digits; src[i] = bcd_src[4i+3:4i].
- offset  in  OFFW  source index shown on display digit 0.
- update_mask  in  SRC_DIGITS  bit i set means source digit i is being edited.
- blink_en  in  1  enables blinking of masked digits.
- digit_sel  out  DIGITS  one-hot, active-high select of the displayed position.
- bcd_out  out  4  BCD value for the selected position.
- frame_start  out  1  one-cycle pulse when a new scan frame begins.

## Operation

- State:
  - Prescaler presc counts 0..SCAN_DIV-1.
  - Digit index idx counts 0..DIGITS-1.
  - Frame counter fcnt counts 0..BLINK_FRAMES-1.
  - blink_phase: 1 = visible.
  - Latched window offset off_q.
  - Registered outputs.
- Tick: presc == SCAN_DIV-1. On a tick, presc goes to 0 and idx advances. Otherwise presc increments.
- Frame wrap: a tick with idx == DIGITS-1.
  - idx goes to 0.
  - off_q loads offset.
  - fcnt increments. When fcnt == BLINK_FRAMES-1, fcnt goes to 0 and blink_phase toggles.
- Source index for position k: s = off_q + k, computed at OFFW+4 bits with no truncation.
- Output value for position k, in priority order:
  1. If s ≥ SRC_DIGITS: BLANK.
  2. Else if update_mask[s] && blink_en && !blink_phase: BLANK.
  3. Else: src[s].
- Outputs are registered every cycle:
  - digit_sel = 1 << idx_next.
  - bcd_out = value for idx_next.
  - frame_start = 1 when the cycle starts a frame.
- Offset changes take effect only at a frame wrap. Changes mid-frame do not tear the display.
- bcd_src, update_mask and blink_en are sampled live. They are not frame-latched.
- bcd_out passes source values unchecked. Non-BCD codes pass through.
- Simultaneous events: an offset change in the wrap cycle is captured for the new frame. A blink toggle and a frame wrap in the same cycle apply together to the first digit of the new frame.

## Timing

- During reset:
  - presc = 0, idx = 0, fcnt = 0, blink_phase = 1, off_q = 0.
  - digit_sel = 0 (all off), bcd_out = BLANK, frame_start = 0.
- First cycle after reset is released:
  - digit_sel = 1 (position 0), showing src[0].
  - frame_start = 1.
  - The frame uses off_q = 0.
- Each position is selected for exactly SCAN_DIV cycles. A frame is DIGITS*SCAN_DIV cycles.
- Blink half-period is BLINK_FRAMES*DIGITS*SCAN_DIV cycles.
- Latency from bcd_src, update_mask or blink_en to bcd_out is 1 cycle, while that position is selected.
- Offset latency: visible from the next frame_start onward.
- Reset asserted mid-operation: the state above holds on the next edge. After release, the module restarts at position 0 with frame_start and blink_phase visible.
- digit_sel is always one-hot outside reset and all-zero in reset. No cycle has two positions selected.

## Test plan

Bench parameters: DIGITS=4, SRC_DIGITS=6, SCAN_DIV=3, BLINK_FRAMES=2. Source digits: src0..src5 = 9,1,5,4,3,2.

- Reset: hold reset 2 cycles -> digit_sel=0000, bcd_out=F, frame_start=0. First cycle after release -> digit_sel=0001, bcd_out=9, frame_start=1.
- Scan with offset=0 -> bcd_out is 9,1,5,4, each held 3 cycles, with digit_sel 0001,0010,0100,1000. At cycle 12, digit_sel=0001 and frame_start=1 again; frame_start is 0 in all other cycles.
- Offset=2 applied at cycle 4 -> current frame still shows 9,1,5,4. Next frame shows 5,4,3,2.
- Offset=4 -> next frame shows 3,2,F,F. Offset=7 -> next frame shows F,F,F,F.
- update_mask=000100, blink_en=1, offset=0:
  - Position 2 shows 5 in frames 0-1, F in frames 2-3, 5 in frames 4-5.
  - Clearing blink_en during an F phase -> 5 within 1 cycle.
- Reset pulse while position 2 is selected in frame 3 -> after release, digit_sel=0001 with frame_start=1, and masked position 2 is visible (5) for two frames.
